// File: rtl/bit_frame_pkg.sv
// Shared types and defaults for the serial bit-frame deserializer.
package bit_frame_pkg;

  typedef enum logic {
    StHunt,
    StPayload
  } state_e;

  localparam int unsigned DefWidth   = 8;
  localparam int unsigned DefSyncLen = 4;
  localparam logic [3:0]  DefSyncPat = 4'b1011;
  localparam int unsigned DefCntW    = 8;

  // Payload bit counter width; counts 0 .. width-1.
  function automatic int unsigned payload_cnt_w(input int unsigned width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/bit_frame_fifo2.sv
// Two-entry shift FIFO; head slot is zero whenever the FIFO is empty.
module bit_frame_fifo2
  import bit_frame_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid
);

  logic [1:0]       cnt_q, cnt_d, cnt_mid;
  logic [WIDTH-1:0] s0_q, s0_d, s1_q, s1_d;
  logic             pop_ok, push_ok;

  always_comb begin
    s0_d    = s0_q;
    s1_d    = s1_q;
    cnt_d   = cnt_q;
    cnt_mid = cnt_q;
    pop_ok  = pop && (cnt_q != 2'd0);
    // A full FIFO still takes a push when the head leaves in the same cycle.
    push_ok = push && ((cnt_q != 2'd2) || pop_ok);

    if (pop_ok) begin
      s0_d    = s1_q;
      s1_d    = '0;
      cnt_mid = cnt_q - 2'd1;
    end
    cnt_d = cnt_mid;
    if (push_ok) begin
      if (cnt_mid == 2'd0) begin
        s0_d = push_data;
      end else begin
        s1_d = push_data;
      end
      cnt_d = cnt_mid + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= 2'd0;
      s0_q  <= '0;
      s1_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      s0_q  <= s0_d;
      s1_q  <= s1_d;
    end
  end

  assign full  = (cnt_q == 2'd2);
  assign valid = (cnt_q != 2'd0);
  assign head  = s0_q;

endmodule

// File: rtl/bit_frame_deser.sv
// Serial deserializer: hunts for a sync header, collects a WIDTH-bit word MSB-first,
// buffers it in a 2-entry FIFO and counts words lost to backpressure.
module bit_frame_deser
  import bit_frame_pkg::*;
#(
  parameter int unsigned          WIDTH    = DefWidth,
  parameter int unsigned          SYNC_LEN = DefSyncLen,
  parameter logic [SYNC_LEN-1:0]  SYNC_PAT = DefSyncPat,
  parameter int unsigned          CNT_W    = DefCntW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             in_frame
);

  localparam int unsigned PcW   = payload_cnt_w(WIDTH);
  localparam int unsigned FillW = $clog2(SYNC_LEN + 1);

  state_e              state_q, state_d;
  // Only the oldest SYNC_LEN-1 bits are kept; the current bit completes the window.
  logic [SYNC_LEN-2:0] sr_q, sr_d;
  logic [FillW-1:0]    fill_q, fill_d;
  logic [PcW-1:0]      pcnt_q, pcnt_d;
  logic [WIDTH-2:0]    word_q, word_d;
  logic [CNT_W-1:0]    drop_q, drop_d;

  logic [SYNC_LEN-1:0] window;
  logic [WIDTH-1:0]    word_full;
  logic                push, full, pop, drop;

  assign window    = {sr_q, in_bit};
  assign word_full = {word_q, in_bit};
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    fill_d  = fill_q;
    pcnt_d  = pcnt_q;
    word_d  = word_q;
    push    = 1'b0;

    if (in_valid) begin
      unique case (state_q)
        StHunt: begin
          sr_d = window[SYNC_LEN-2:0];
          if (fill_q != FillW'(SYNC_LEN)) begin
            fill_d = fill_q + 1'b1;
          end
          if ((window == SYNC_PAT) && (fill_q >= FillW'(SYNC_LEN - 1))) begin
            state_d = StPayload;
            pcnt_d  = '0;
          end
        end
        StPayload: begin
          word_d = word_full[WIDTH-2:0];
          pcnt_d = pcnt_q + 1'b1;
          if (pcnt_q == PcW'(WIDTH - 1)) begin
            push    = 1'b1;
            state_d = StHunt;
            sr_d    = '0;
            fill_d  = '0;
            pcnt_d  = '0;
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  assign drop   = push && full && !pop;
  assign drop_d = (drop && (drop_q != {CNT_W{1'b1}})) ? drop_q + 1'b1 : drop_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StHunt;
      sr_q    <= '0;
      fill_q  <= '0;
      pcnt_q  <= '0;
      word_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      fill_q  <= fill_d;
      pcnt_q  <= pcnt_d;
      word_q  <= word_d;
      drop_q  <= drop_d;
    end
  end

  bit_frame_fifo2 #(
    .WIDTH(WIDTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(word_full),
    .full     (full),
    .pop      (pop),
    .head     (out_data),
    .valid    (out_valid)
  );

  assign drop_cnt = drop_q;
  assign in_frame = (state_q == StPayload);

endmodule

// File: doc/bit_frame_deser.md
Name: bit_frame_deser

Overview:
- Downstream consumer of a 1-bit-per-cycle serial output stream, such as the single-bit output of a generated top_level regression design.
- Hunts for a fixed sync header in the stream, then collects a WIDTH-bit payload MSB-first.
- Emits each completed word through a 2-entry buffered valid/ready interface.
- Counts words dropped because of output backpressure.

Parameters:
- WIDTH, 8, payload bits per frame (>=2).
- SYNC_LEN, 4, sync header length in bits (>=2).
- SYNC_PAT, 4'b1011, sync header value; the first-received bit is the MSB.
- CNT_W, 8, width of the drop counter.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-low: rst==0 at a rising edge of clk resets the block.
- in_bit  in  1  serial data bit.
- in_valid  in  1  in_bit is consumed this cycle. There is no backpressure upstream.
- out_data  out  WIDTH  head-of-buffer word.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts the word when out_valid&&out_ready.
- drop_cnt  out  CNT_W  saturating count of dropped words.
- in_frame  out  1  high while the FSM is in PAYLOAD.

Behaviour:
- Reset values: FSM=HUNT, sync shift reg=0, sync fill count=0, payload count=0, buffer empty, out_valid=0, out_data=0, drop_cnt=0, in_frame=0.
- Reset mid-frame discards the partial word and all buffered words.
- Cycles with in_valid==0 change no input-side state.
- The output side still pops on out_valid&&out_ready regardless of in_valid.
- HUNT state:
  - Each accepted bit shifts into the sync register: sr <= {sr[SYNC_LEN-2:0], in_bit}.
  - The fill count increments, saturating at SYNC_LEN.
  - Match condition: the window {sr[SYNC_LEN-2:0], in_bit} == SYNC_PAT AND the fill count reaches >=SYNC_LEN including the current bit.
  - On match: next state PAYLOAD, payload count=0.
  - Windows overlap, so 1 1 0 1 1 matches on its 5th bit.
- PAYLOAD state:
  - Each accepted bit shifts into the word LSB end: word <= {word[WIDTH-2:0], in_bit}. The count increments.
  - The bit accepted when count==WIDTH-1 completes the word. In that cycle:
    - The completed word is pushed to the buffer.
    - FSM returns to HUNT.
    - Sync register and fill count are cleared.
  - Sync patterns inside the payload are ignored.
  - in_frame = (state==PAYLOAD).
- Output buffer (2-entry FIFO):
  - A push is accepted if the buffer is not full, or if it is full and a pop occurs in the same cycle.
  - Otherwise the word is dropped and drop_cnt increments, saturating at 2^CNT_W-1.
  - A push into an empty buffer makes out_valid=1 with out_data=word on the following cycle; latency is 1 cycle after the final payload bit.
  - Words leave in arrival order.
  - Simultaneous push and pop on a 1-entry buffer keeps the occupancy at 1 and advances the head.
  - out_data is held stable while out_valid&&!out_ready.
  - out_data reads 0 when the buffer is empty.
- All outputs are registered or derived from registered state. There is no combinational path from in_bit/in_valid to the outputs.
- out_ready may combinationally affect only internal push acceptance.

Decomposition:
- Package bit_frame_pkg holds:
  - the FSM enum typedef (HUNT, PAYLOAD), 1 bit;
  - default constants for WIDTH, SYNC_LEN, SYNC_PAT, CNT_W;
  - a localparam function for the payload counter width, $clog2(WIDTH).
- One sub-module, bit_frame_fifo2:
  - a 2-entry FIFO parameterised by WIDTH;
  - interface push/push_data/full/pop/head/valid;
  - full-with-pop push acceptance is implemented inside it.
- Sync detection, the payload shifter and drop_cnt stay in the top.

Test Plan:
- Reset: hold rst=0 for 2 cycles with random in_bit/in_valid -> out_valid=0, out_data=0, drop_cnt=0, in_frame=0.
- Basic frame: bits 1,0,1,1 then 0x3C MSB-first (0,0,1,1,1,1,0,0) with in_valid=1, out_ready=1 -> in_frame=1 from the cycle after the 4th bit, out_valid=1 with out_data=8'h3C exactly one cycle after the 12th bit, out_valid=0 the next cycle.
- Overlap and gaps: send 1,1,0,1,1 with in_valid=0 idle cycles between bits, then payload 0xB0 -> sync on the 5th valid bit, out_data=8'hB0. Embedded 1011 in the payload does not restart framing.
- Backpressure/drop: out_ready=0, send 3 frames 0x11, 0x22, 0x33 -> drop_cnt=1 after the third. Then out_ready=1 -> 0x11 then 0x22 appear on consecutive cycles, then out_valid=0.
- Full with simultaneous pop: buffer holding 0x11, 0x22; assert out_ready=1 in the same cycle the final bit of 0x44 arrives -> no drop (drop_cnt unchanged), output sequence 0x11, 0x22, 0x44.
- Reset mid-operation: rst=0 after 5 payload bits with one word buffered -> next cycle out_valid=0, in_frame=0, drop_cnt=0. A subsequent full frame 0x5A is received correctly.
